mc_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core. Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
- Drives instruction- and data-memory request handshakes.
- Gates the write enables produced by the combinational decoder: PC, IR, register file and RAM.
- Sits between the opcode field of the IR and the datapath enables. Halts on illegal opcode or memory timeout.

---
 rtl/mc_seq_pkg.sv | 30 +++
 rtl/mc_wait_timer.sv | 34 +++
 rtl/mc_sequencer.sv | 156 +++++++++++++++
 tb/tb_mc_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// Shared state encoding and RV32I major-opcode constants for the multi-cycle sequencer.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
           (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles a memory request is held unacknowledged; flags the cycle that reaches the limit.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Count holds the number of earlier unacked cycles, so limit-1 marks the final allowed one.
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT - 1);
      assign o_expired = (r_cnt == Limit);
    end
  endgenerate

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Optional retired-instruction counter output o_instret when MC_SEQ_INSTRET_EN is defined.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [6:0]  i_opcode,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_dmem_req,
  input  logic        i_dmem_ack,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_rf_we_en,
  output logic        o_ram_we_en,
  output logic [2:0]  o_state,
  output logic        o_halted,
  output logic        o_bus_err,
  output logic        o_illegal
`ifdef MC_SEQ_INSTRET_EN
  ,
  output logic [31:0] o_instret
`endif
);

  state_e r_state, w_state_next;
  logic   r_bus_err, r_illegal;
  logic   w_set_bus_err, w_set_illegal;
  logic   w_timer_en, w_timer_clear, w_expired;
  logic   w_is_load, w_is_store, w_is_branch;

  assign w_is_load   = (i_opcode == OP_LOAD);
  assign w_is_store  = (i_opcode == OP_STORE);
  assign w_is_branch = (i_opcode == OP_BRANCH);

  always_comb begin
    w_state_next  = r_state;
    o_imem_req    = 1'b0;
    o_dmem_req    = 1'b0;
    o_ir_we       = 1'b0;
    o_pc_we       = 1'b0;
    o_rf_we_en    = 1'b0;
    o_ram_we_en   = 1'b0;
    w_timer_en    = 1'b0;
    w_set_bus_err = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      StIdle: if (i_run) w_state_next = StFetch;
      StFetch: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_we      = 1'b1;
          w_state_next = StDecode;
        end else begin
          w_timer_en = 1'b1;
          if (w_expired) begin
            w_state_next  = StHalt;
            w_set_bus_err = 1'b1;
          end
        end
      end
      StDecode: begin
        if (is_legal_op(i_opcode)) begin
          w_state_next = StExec;
        end else begin
          w_state_next  = StHalt;
          w_set_illegal = 1'b1;
        end
      end
      StExec: w_state_next = (w_is_load || w_is_store) ? StMem : StWb;
      StMem: begin
        o_dmem_req  = 1'b1;
        o_ram_we_en = w_is_store;
        if (i_dmem_ack) begin
          if (w_is_store) begin
            o_pc_we      = 1'b1;
            w_state_next = i_run ? StFetch : StIdle;
          end else begin
            w_state_next = StWb;
          end
        end else begin
          w_timer_en = 1'b1;
          if (w_expired) begin
            w_state_next  = StHalt;
            w_set_bus_err = 1'b1;
          end
        end
      end
      StWb: begin
        o_pc_we      = 1'b1;
        o_rf_we_en   = !(w_is_store || w_is_branch);
        w_state_next = i_run ? StFetch : StIdle;
      end
      StHalt: w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
    // Nothing may be committed in a cycle that is being reset.
    if (!i_rst_n) begin
      o_imem_req  = 1'b0;
      o_dmem_req  = 1'b0;
      o_ir_we     = 1'b0;
      o_pc_we     = 1'b0;
      o_rf_we_en  = 1'b0;
      o_ram_we_en = 1'b0;
    end
  end

  // Any state change restarts the count, so it is zero on entry to FETCH or MEM.
  assign w_timer_clear = (w_state_next != r_state);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_timer_clear),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  assign o_state   = r_state;
  assign o_halted  = (r_state == StHalt);
  assign o_bus_err = r_bus_err;
  assign o_illegal = r_illegal;

`ifdef MC_SEQ_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_instret <= '0;
    end else if (o_pc_we) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign o_instret = r_instret;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces built from the sequencing rules.
module tb_mc_sequencer;

  localparam int unsigned T = 15;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [6:0] R_OP = 7'b0110011, LD_OP = 7'b0000011, ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n, run, iack, dack;
  logic [6:0] op;
  logic imem_req, dmem_req, ir_we, pc_we, rf_we_en, ram_we_en, halted, bus_err, illegal;
  logic [2:0] state;
`ifdef MC_SEQ_INSTRET_EN
  logic [31:0] instret;
`endif

  mc_sequencer #(
    .MEM_TIMEOUT(T)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_run      (run),
    .i_opcode   (op),
    .o_imem_req (imem_req),
    .i_imem_ack (iack),
    .o_dmem_req (dmem_req),
    .i_dmem_ack (dack),
    .o_ir_we    (ir_we),
    .o_pc_we    (pc_we),
    .o_rf_we_en (rf_we_en),
    .o_ram_we_en(ram_we_en),
    .o_state    (state),
    .o_halted   (halted),
    .o_bus_err  (bus_err),
    .o_illegal  (illegal)
`ifdef MC_SEQ_INSTRET_EN
    ,
    .o_instret  (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [6:0] op;
    logic run, iack, dack;
    logic ireq, dreq, irwe, pcwe, rfwe, ramwe, hlt, berr, ill;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        need_idle;
  logic [31:0] exp_instret;

  function automatic logic legal(input logic [6:0] o);
    logic [6:0] tbl[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    foreach (tbl[i]) if (tbl[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Acks are random noise except in the state that consumes them.
  function automatic ent_t mk(input logic [2:0] st, input logic [6:0] o);
    ent_t e;
    e.st = st; e.op = o;
    e.run  = 1'($urandom);
    e.iack = (st != S_FETCH) ? 1'($urandom) : 1'b0;
    e.dack = (st != S_MEM) ? 1'($urandom) : 1'b0;
    e.ireq = 0; e.dreq = 0; e.irwe = 0; e.pcwe = 0; e.rfwe = 0; e.ramwe = 0;
    e.hlt = 0; e.berr = 0; e.ill = 0;
    return e;
  endfunction

  function automatic void add_halt(input logic [6:0] o, input logic b, input logic il);
    ent_t e;
    for (int k = 0; k < 20; k++) begin
      e = mk(S_HALT, o);
      e.run = 1'b1; e.hlt = 1'b1; e.berr = b; e.ill = il;
      q.push_back(e);
    end
  endfunction

  // df/dm: number of unacked request cycles before the ack; cont: run level at retirement.
  function automatic void build(input logic [6:0] o, input int df, input int dm, input logic cont);
    ent_t e;
    logic is_ld, is_st;
    is_ld = (o == LD_OP);
    is_st = (o == ST_OP);
    if (need_idle) begin
      e = mk(S_IDLE, o); e.run = 1'b1; q.push_back(e);
    end
    need_idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      e = mk(S_FETCH, o); e.ireq = 1'b1;
      if (i == df) begin
        e.iack = 1'b1; e.irwe = 1'b1; q.push_back(e);
        break;
      end
      q.push_back(e);
      if (i == T - 1) begin
        add_halt(o, 1'b1, 1'b0);
        return;
      end
    end
    q.push_back(mk(S_DEC, o));
    if (!legal(o)) begin
      add_halt(o, 1'b0, 1'b1);
      return;
    end
    q.push_back(mk(S_EXEC, o));
    if (is_ld || is_st) begin
      for (int j = 0; j < 100; j++) begin
        e = mk(S_MEM, o); e.dreq = 1'b1; e.ramwe = is_st;
        if (j == dm) begin
          e.dack = 1'b1;
          if (is_st) begin e.pcwe = 1'b1; e.run = cont; end
          q.push_back(e);
          break;
        end
        q.push_back(e);
        if (j == T - 1) begin
          add_halt(o, 1'b1, 1'b0);
          return;
        end
      end
    end
    if (!is_st) begin
      e = mk(S_WB, o); e.pcwe = 1'b1; e.rfwe = (o != BR_OP); e.run = cont;
      q.push_back(e);
    end
    need_idle = !cont;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply(input ent_t e);
    run = e.run; iack = e.iack; dack = e.dack; op = e.op;
    @(negedge clk);
    chk("state", 32'(state), 32'(e.st));
    chk("imem_req", 32'(imem_req), 32'(e.ireq));
    chk("dmem_req", 32'(dmem_req), 32'(e.dreq));
    chk("ir_we", 32'(ir_we), 32'(e.irwe));
    chk("pc_we", 32'(pc_we), 32'(e.pcwe));
    chk("rf_we_en", 32'(rf_we_en), 32'(e.rfwe));
    chk("ram_we_en", 32'(ram_we_en), 32'(e.ramwe));
    chk("halted", 32'(halted), 32'(e.hlt));
    chk("bus_err", 32'(bus_err), 32'(e.berr));
    chk("illegal", 32'(illegal), 32'(e.ill));
`ifdef MC_SEQ_INSTRET_EN
    chk("instret", instret, exp_instret);
`endif
    if (e.pcwe) exp_instret++;
    @(posedge clk);
    #1;
  endtask

  task automatic play_n(input int n);
    for (int k = 0; k < n && q.size() > 0; k++) apply(q.pop_front());
  endtask

  task automatic play_all();
    while (q.size() > 0) apply(q.pop_front());
  endtask

  // One reset cycle with every input trying to provoke activity.
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b1; iack = 1'b1; dack = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    need_idle = 1'b1;
    exp_instret = '0;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    rst_n = 1'b0; run = 1'b0; iack = 1'b0; dack = 1'b0; op = '0;
    need_idle = 1'b1; exp_instret = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state held in IDLE while run is low.
    for (int k = 0; k < 2; k++) begin
      e = mk(S_IDLE, R_OP); e.run = 1'b0; q.push_back(e);
    end
    build(R_OP, 0, 0, 1'b1);
    build(LD_OP, 0, 3, 1'b1);
    build(ST_OP, 0, 2, 1'b1);
    build(R_OP, 0, 0, 1'b0);
    build(BR_OP, 1, 0, 1'b1);
    build(ST_OP, 2, 0, 1'b0);
    play_all();

    for (int n = 0; n < 60; n++) begin
      build(ops[$urandom_range(0, 8)], int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            ($urandom_range(0, 3) != 0));
      play_all();
    end

    build(7'h00, 0, 0, 1'b1);
    play_all();
    do_reset();

    build(R_OP, 40, 0, 1'b1);
    play_all();
    do_reset();

    build(R_OP, int'(T) - 1, 0, 1'b1);
    build(LD_OP, 0, int'(T) - 1, 1'b1);
    play_all();

    build(ST_OP, 0, 40, 1'b1);
    play_all();
    do_reset();

    // Reset while in MEM: IDLE,F,D,E,M,M then reset; the following IDLE entry checks the aftermath.
    build(LD_OP, 0, 10, 1'b1);
    play_n(6);
    do_reset();
    build(R_OP, 0, 0, 1'b0);
    play_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
